// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave backed by a word-addressed RAM with byte strobes.
// Independent write (AW/W/B) and read (AR/R) channels; out-of-range -> SLVERR.
//
// Ports:
//   aclk, areset             clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*          write address, write data, write response
//   s_ar*/s_r*               read address, read data/response
module axi_lite_ram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic {R_ACCEPT, R_DATA} r_state_t;

    w_state_t w_state, w_state_n;
    r_state_t r_state, r_state_n;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              aw_fire, w_fire, ar_fire, w_commit;
    logic [ADDR_W-1:0] w_addr, w_off, r_off;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_in_range, r_in_range;
    logic [IDX_W-1:0]  w_idx, r_idx;

    assign s_awready = (w_state == W_ACCEPT) && !aw_held;
    assign s_wready  = (w_state == W_ACCEPT) && !w_held;
    assign s_bvalid  = (w_state == W_RESP);
    assign s_arready = (r_state == R_ACCEPT);
    assign s_rvalid  = (r_state == R_DATA);

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    assign ar_fire = s_arvalid && s_arready;

    // On the completing edge the live channel payload bypasses the latch.
    assign w_addr = aw_fire ? s_awaddr : aw_addr_q;
    assign w_data = w_fire ? s_wdata : wdata_q;
    assign w_strb = w_fire ? s_wstrb : wstrb_q;

    // Subtract first so the window test is a single high-bits-zero check.
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = (w_addr >= BASE_ADDR) &&
                        ((w_off >> (IDX_W + 2)) == '0);
    assign w_idx      = w_off[IDX_W+1:2];

    assign r_off      = s_araddr - BASE_ADDR;
    assign r_in_range = (s_araddr >= BASE_ADDR) &&
                        ((r_off >> (IDX_W + 2)) == '0);
    assign r_idx      = r_off[IDX_W+1:2];

    always_comb begin
        w_state_n = w_state;
        w_commit  = 1'b0;
        unique case (w_state)
            W_ACCEPT: begin
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    w_commit  = 1'b1;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) w_state_n = W_ACCEPT;
            end
            default: w_state_n = W_ACCEPT;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state   <= W_ACCEPT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            s_bresp   <= OKAY;
        end else begin
            w_state <= w_state_n;
            if (aw_fire) aw_addr_q <= s_awaddr;
            if (w_fire) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            // Held flags drop at commit; readies stay low via W_RESP.
            aw_held <= (aw_held || aw_fire) && !w_commit;
            w_held  <= (w_held || w_fire) && !w_commit;
            if (w_commit) s_bresp <= w_in_range ? OKAY : SLVERR;
        end
    end

    // RAM is never reset; readies are high during reset, so gate commit.
    always_ff @(posedge aclk) begin
        if (w_commit && w_in_range && !areset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        r_state_n = r_state;
        unique case (r_state)
            R_ACCEPT: if (s_arvalid) r_state_n = R_DATA;
            R_DATA:   if (s_rready)  r_state_n = R_ACCEPT;
            default:  r_state_n = R_ACCEPT;
        endcase
    end

    // Non-blocking read of mem: a same-edge write is not yet visible.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_ACCEPT;
            s_rdata <= '0;
            s_rresp <= OKAY;
        end else begin
            r_state <= r_state_n;
            if (ar_fire) begin
                s_rdata <= r_in_range ? mem[r_idx] : '0;
                s_rresp <= r_in_range ? OKAY : SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Bench for axi_lite_ram_slave: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_axi_lite_ram_slave;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    axi_lite_ram_slave dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: pending-transaction queues and a sparse word memory.
    logic [31:0] mm [int unsigned];
    logic [31:0] awq [$];
    logic [35:0] wq [$];
    bit          b_pend, r_pend;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            awq.delete();
            wq.delete();
            b_pend  = 0;
            r_pend  = 0;
            m_bresp = 2'b00;
            m_rresp = 2'b00;
            m_rdata = '0;
        end else begin
            // Read is evaluated first so it observes pre-write contents.
            if (r_pend) begin
                if (s_rready) r_pend = 0;
            end else if (s_arvalid) begin
                r_pend = 1;
                if (s_araddr < 32'h1000) begin
                    m_rdata = mm.exists(s_araddr / 4) ? mm[s_araddr / 4] : '0;
                    m_rresp = 2'b00;
                end else begin
                    m_rdata = '0;
                    m_rresp = 2'b10;
                end
            end
            if (b_pend) begin
                if (s_bready) b_pend = 0;
            end else begin
                if (s_awvalid && awq.size() == 0) awq.push_back(s_awaddr);
                if (s_wvalid && wq.size() == 0)
                    wq.push_back({s_wstrb, s_wdata});
                if (awq.size() != 0 && wq.size() != 0) begin
                    logic [31:0] a;
                    logic [35:0] sw;
                    logic [31:0] cur;
                    a  = awq.pop_front();
                    sw = wq.pop_front();
                    b_pend = 1;
                    if (a < 32'h1000) begin
                        cur = mm.exists(a / 4) ? mm[a / 4] : '0;
                        for (int b = 0; b < 4; b++)
                            if (sw[32 + b]) cur[8*b +: 8] = sw[8*b +: 8];
                        mm[a / 4] = cur;
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (!areset) begin
            chk("awready", 32'(s_awready), 32'(!b_pend && awq.size() == 0));
            chk("wready",  32'(s_wready),  32'(!b_pend && wq.size() == 0));
            chk("bvalid",  32'(s_bvalid),  32'(b_pend));
            chk("arready", 32'(s_arready), 32'(!r_pend));
            chk("rvalid",  32'(s_rvalid),  32'(r_pend));
            if (b_pend) chk("bresp", 32'(s_bresp), 32'(m_bresp));
            if (r_pend) begin
                chk("rdata", s_rdata, m_rdata);
                chk("rresp", 32'(s_rresp), 32'(m_rresp));
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        bit aw_ok, w_ok, got;
        int cnt;
        s_awaddr = a; s_awvalid = 1'b1;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        s_bready = 1'b1;
        cnt = 0;
        while ((s_awvalid || s_wvalid) && cnt < 20) begin
            @(negedge aclk);
            aw_ok = s_awready;
            w_ok  = s_wready;
            @(posedge aclk); #1;
            if (aw_ok) s_awvalid = 1'b0;
            if (w_ok)  s_wvalid = 1'b0;
            cnt++;
        end
        got = 0;
        resp = 2'b11;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge aclk);
            if (s_bvalid) begin
                got = 1;
                resp = s_bresp;
            end
        end
        n_cmp++;
        if (!got || s_awvalid || s_wvalid) begin
            n_bad++;
            $display("FAIL write_timeout: addr %h got no B response", a);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
        bit ar_ok, got;
        int cnt;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        cnt = 0;
        while (s_arvalid && cnt < 20) begin
            @(negedge aclk);
            ar_ok = s_arready;
            @(posedge aclk); #1;
            if (ar_ok) s_arvalid = 1'b0;
            cnt++;
        end
        got = 0;
        d = '0;
        resp = 2'b11;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge aclk);
            if (s_rvalid) begin
                got = 1;
                d = s_rdata;
                resp = s_rresp;
            end
        end
        n_cmp++;
        if (!got || s_arvalid) begin
            n_bad++;
            $display("FAIL read_timeout: addr %h got no R response", a);
        end
        s_arvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        #3;
        chk("rst_awready", 32'(s_awready), 32'd1);
        chk("rst_wready",  32'(s_wready),  32'd1);
        chk("rst_arready", 32'(s_arready), 32'd1);
        chk("rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rst_rdata",   s_rdata,        32'd0);
        #9 areset = 1'b0;
        @(posedge aclk); #1;

        // Full-word write and readback.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, r);
        chk("t1_bresp", 32'(r), 32'd0);
        do_read(32'h10, d, r);
        chk("t1_rdata", d, 32'hDEADBEEF);
        chk("t1_rresp", 32'(r), 32'd0);

        // Partial strobe merges with existing data.
        do_write(32'h10, 32'h12345678, 4'h3, r);
        do_read(32'h10, d, r);
        chk("t2_rdata", d, 32'hDEAD5678);

        // AW three cycles ahead of W.
        s_bready = 1'b1;
        s_awaddr = 32'h50; s_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        @(negedge aclk);
        chk("t3_awready_low", 32'(s_awready), 32'd0);
        chk("t3_bvalid_c1", 32'(s_bvalid), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t3_bvalid_c2", 32'(s_bvalid), 32'd0);
        @(posedge aclk); #1;
        s_wdata = 32'h0A0B0C0D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge aclk);
        chk("t3_bvalid_c3", 32'(s_bvalid), 32'd0);
        @(posedge aclk); #1;
        s_wvalid = 1'b0;
        @(negedge aclk);
        chk("t3_bvalid_c4", 32'(s_bvalid), 32'd1);
        @(posedge aclk); #1;
        do_read(32'h50, d, r);
        chk("t3_rdata", d, 32'h0A0B0C0D);

        // Out of range: SLVERR, no alias onto word 0; last word is fine.
        do_write(32'h0, 32'hA5A5A5A5, 4'hF, r);
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, r);
        chk("t4_bresp", 32'(r), 32'd2);
        do_read(32'h1000, d, r);
        chk("t4_rresp", 32'(r), 32'd2);
        chk("t4_rdata", d, 32'd0);
        do_read(32'h0, d, r);
        chk("t4_word0", d, 32'hA5A5A5A5);
        chk("t4_word0_resp", 32'(r), 32'd0);
        do_write(32'hFFE, 32'h7E7E7E7E, 4'hF, r);
        chk("t4_top_bresp", 32'(r), 32'd0);
        do_read(32'hFFC, d, r);
        chk("t4_top_rdata", d, 32'h7E7E7E7E);

        // B backpressure for five cycles.
        s_bready = 1'b0;
        s_awaddr = 32'h40; s_awvalid = 1'b1;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("t5_bvalid", 32'(s_bvalid), 32'd1);
            chk("t5_bresp", 32'(s_bresp), 32'd0);
            chk("t5_awready", 32'(s_awready), 32'd0);
            chk("t5_wready", 32'(s_wready), 32'd0);
            @(posedge aclk); #1;
        end
        s_bready = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t5_awready_back", 32'(s_awready), 32'd1);
        @(posedge aclk); #1;
        do_read(32'h40, d, r);
        chk("t5_rdata", d, 32'hCAFEF00D);

        // Same-edge commit and capture return the old word.
        do_write(32'h20, 32'h1, 4'hF, r);
        s_awaddr = 32'h20; s_awvalid = 1'b1;
        s_wdata = 32'h2; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 32'h20; s_arvalid = 1'b1;
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge aclk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(negedge aclk);
        chk("t6_rvalid", 32'(s_rvalid), 32'd1);
        chk("t6_rdata_old", s_rdata, 32'h1);
        @(posedge aclk); #1;
        do_read(32'h20, d, r);
        chk("t6_rdata_new", d, 32'h2);

        // Reset mid-write: aborts, RAM untouched.
        do_write(32'h30, 32'h11112222, 4'hF, r);
        do_read(32'h30, d, r);
        s_bready = 1'b0;
        s_awaddr = 32'h30; s_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        #2 areset = 1'b1;
        #1;
        chk("t7_awready", 32'(s_awready), 32'd1);
        chk("t7_wready",  32'(s_wready),  32'd1);
        chk("t7_arready", 32'(s_arready), 32'd1);
        chk("t7_bvalid",  32'(s_bvalid),  32'd0);
        chk("t7_rvalid",  32'(s_rvalid),  32'd0);
        chk("t7_bresp",   32'(s_bresp),   32'd0);
        chk("t7_rdata",   s_rdata,        32'd0);
        s_wvalid = 1'b0;
        @(posedge aclk); #3;
        areset = 1'b0;
        @(posedge aclk); #1;
        do_read(32'h30, d, r);
        chk("t7_ram_kept", d, 32'h11112222);

        repeat (3) @(posedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
